// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the byte FIFO write port among N_REQ requesters.
// One beat per cycle is registered into the output stage; delivered bytes are counted.
module fifo_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [2*N_REQ-1:0]    req_size,
  input  logic [64*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  input  logic                  fifo_ready_in,
  output logic                  fifo_valid_in,
  output logic [1:0]            fifo_size,
  output logic [63:0]           fifo_data_in,
  output logic [PTR_W-1:0]      grant_id,
  output logic [CNT_W-1:0]      bytes_written
);

  logic                 fifo_valid_q, fifo_valid_d;
  logic [1:0]           fifo_size_q, fifo_size_d;
  logic [63:0]          fifo_data_q, fifo_data_d;
  logic [PTR_W-1:0]     grant_id_q, grant_id_d;
  logic [PTR_W-1:0]     last_ptr_q, last_ptr_d;
  logic [CNT_W-1:0]     bytes_q, bytes_d;

  logic                 found;
  logic [PTR_W-1:0]     winner;
  logic                 load_en;

  // Returns {found, index}; scanning offsets high-to-low lets the nearest one after last win.
  function automatic logic [PTR_W:0] rr_pick(input logic [N_REQ-1:0] vld,
                                             input logic [PTR_W-1:0] last);
    logic [PTR_W:0] res;
    int             idx;
    res = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (vld[idx]) res = {1'b1, PTR_W'(idx)};
    end
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] size_bytes(input logic [1:0] sz);
    return CNT_W'(1) << sz;
  endfunction

  always_comb begin
    {found, winner} = rr_pick(req_valid, last_ptr_q);
    load_en         = !fifo_valid_q || fifo_ready_in;

    req_ready = '0;
    if (reset_n && found && load_en) req_ready[winner] = 1'b1;

    fifo_valid_d = fifo_valid_q;
    fifo_size_d  = fifo_size_q;
    fifo_data_d  = fifo_data_q;
    grant_id_d   = grant_id_q;
    last_ptr_d   = last_ptr_q;
    bytes_d      = bytes_q;

    if (fifo_valid_q && fifo_ready_in) bytes_d = bytes_q + size_bytes(fifo_size_q);

    if (load_en) begin
      if (found) begin
        fifo_valid_d = 1'b1;
        fifo_size_d  = req_size[2*int'(winner) +: 2];
        fifo_data_d  = req_data[64*int'(winner) +: 64];
        grant_id_d   = winner;
        last_ptr_d   = winner;
      end else begin
        fifo_valid_d = 1'b0;
      end
    end
  end

  // Output stage; reset discards any held beat without counting it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fifo_valid_q <= 1'b0;
      fifo_size_q  <= '0;
      fifo_data_q  <= '0;
      grant_id_q   <= '0;
      last_ptr_q   <= PTR_W'(N_REQ - 1);
      bytes_q      <= '0;
    end else begin
      fifo_valid_q <= fifo_valid_d;
      fifo_size_q  <= fifo_size_d;
      fifo_data_q  <= fifo_data_d;
      grant_id_q   <= grant_id_d;
      last_ptr_q   <= last_ptr_d;
      bytes_q      <= bytes_d;
    end
  end

  assign fifo_valid_in = fifo_valid_q;
  assign fifo_size     = fifo_size_q;
  assign fifo_data_in  = fifo_data_q;
  assign grant_id      = grant_id_q;
  assign bytes_written = bytes_q;

endmodule
